// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset; both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronised output, two clk cycles behind d
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, WIDTH data bits LSB first, 1 stop bit, idle high.
// Oversamples by CLKDIV and centre-samples each bit.
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   rx        : serial input, asynchronous to clk, idle high
//   data      : last correctly received word, held until the next good frame
//   valid     : one-cycle strobe when data updates
//   frame_err : one-cycle strobe when the stop bit samples 0
module uart_rx #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned CLKDIV = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rx,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic             frame_err
);

   localparam int unsigned CntW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam int unsigned BitW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [CntW-1:0] CntLast = CntW'(CLKDIV - 1);
   localparam logic [CntW-1:0] CntHalf = CntW'(CLKDIV / 2 - 1);
   localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StBreak
   } state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [BitW-1:0]  bit_q, bit_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;
   logic             rx_s;

   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rx_s)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (!rx_s) state_d = StStart;
         end
         StStart: begin
            // Centre of the start bit: a high line here was only a glitch.
            if (cnt_q == CntHalf) begin
               state_d = rx_s ? StIdle : StData;
               bit_d   = '0;
            end
         end
         StData: begin
            if (cnt_q == CntLast) begin
               // Shift in from the MSB so the LSB-first stream ends in bit order;
               // the widened shift keeps WIDTH == 1 legal.
               shift_d = WIDTH'({rx_s, shift_q} >> 1);
               if (bit_q == BitLast) begin
                  state_d = StStop;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         StStop: begin
            // Leaving mid stop bit lets an immediately following start edge be caught.
            if (cnt_q == CntLast) begin
               if (rx_s) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = StIdle;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = StBreak;
               end
            end
         end
         StBreak: begin
            // Wait out a held-low line so it cannot look like repeated frames.
            if (rx_s) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (state_d != state_q) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx (WIDTH=8, CLKDIV=16): bit-banged frames on rx,
// outputs sampled on the falling clock edge.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;

   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;
   int unsigned cyc    = 0;
   int unsigned n_valid = 0;
   int unsigned n_ferr  = 0;
   int unsigned n_both  = 0;
   int unsigned valid_cyc = 0;
   int unsigned start_cyc = 0;
   logic [7:0]  vq[$];

   uart_rx #(
      .WIDTH  (8),
      .CLKDIV (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor: counts every high cycle, so a stuck strobe inflates the count.
   always @(negedge clk) begin
      if (valid) begin
         n_valid   = n_valid + 1;
         valid_cyc = cyc;
         vq.push_back(data);
      end
      if (frame_err) n_ferr = n_ferr + 1;
      if (valid && frame_err) n_both = n_both + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      assert (obs === exp) else begin
         n_fail = n_fail + 1;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called on a falling edge; returns on a falling edge with rx left at stop_v.
   task automatic send_frame(input logic [7:0] b, input int unsigned per, input logic stop_v);
      rx = 1'b0;
      start_cyc = cyc;
      repeat (per) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (per) @(negedge clk);
      end
      rx = stop_v;
      repeat (per) @(negedge clk);
   endtask

   initial begin
      int unsigned lat;

      // Reset
      repeat (3) @(negedge clk);
      check("reset_data", 32'(data), 32'h00);
      check("reset_valid", 32'(valid), 32'h0);
      check("reset_ferr", 32'(frame_err), 32'h0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("idle_no_valid", n_valid, 0);

      // Back-to-back frames
      send_frame(8'h55, 16, 1'b1);
      send_frame(8'hA3, 16, 1'b1);
      send_frame(8'h00, 16, 1'b1);
      send_frame(8'hFF, 16, 1'b1);
      repeat (40) @(negedge clk);
      check("b2b_count", n_valid, 4);
      check("b2b_word0", 32'(vq[0]), 32'h55);
      check("b2b_word1", 32'(vq[1]), 32'hA3);
      check("b2b_word2", 32'(vq[2]), 32'h00);
      check("b2b_word3", 32'(vq[3]), 32'hFF);
      check("b2b_no_ferr", n_ferr, 0);

      // Glitch shorter than half a bit
      rx = 1'b0;
      repeat (5) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      check("glitch_no_valid", n_valid, 4);
      check("glitch_no_ferr", n_ferr, 0);
      check("glitch_data_held", 32'(data), 32'hFF);

      // Framing error then break held for 40 bit times
      send_frame(8'h3C, 16, 1'b0);
      repeat (39 * 16) @(negedge clk);
      check("ferr_one_pulse", n_ferr, 1);
      check("ferr_no_valid", n_valid, 4);
      check("ferr_data_held", 32'(data), 32'hFF);
      rx = 1'b1;
      repeat (32) @(negedge clk);
      send_frame(8'h81, 16, 1'b1);
      repeat (40) @(negedge clk);
      check("after_break_count", n_valid, 5);
      check("after_break_data", 32'(data), 32'h81);
      check("after_break_ferr", n_ferr, 1);

      // Baud tolerance: slow transmitter
      send_frame(8'hC6, 17, 1'b1);
      repeat (40) @(negedge clk);
      check("slow_count", n_valid, 6);
      check("slow_data", 32'(data), 32'hC6);

      // Baud tolerance: fast transmitter (clear data first via a different word)
      send_frame(8'h01, 16, 1'b1);
      repeat (40) @(negedge clk);
      check("pre_fast_data", 32'(data), 32'h01);
      send_frame(8'hC6, 15, 1'b1);
      repeat (40) @(negedge clk);
      check("fast_count", n_valid, 8);
      check("fast_data", 32'(data), 32'hC6);
      check("tol_no_ferr", n_ferr, 1);

      // Reset during data bit 4 of 0xF0
      rx = 1'b0;
      repeat (16 * 5) @(negedge clk);
      rx = 1'b1;
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_rst_data", 32'(data), 32'h00);
      check("async_rst_valid", 32'(valid), 32'h0);
      check("async_rst_ferr", 32'(frame_err), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6 + 16 * 4) @(negedge clk);
      repeat (40) @(negedge clk);
      check("rst_frame_dropped", n_valid, 8);
      check("rst_data_zero", 32'(data), 32'h00);

      send_frame(8'h12, 16, 1'b1);
      repeat (40) @(negedge clk);
      check("post_rst_count", n_valid, 9);
      check("post_rst_data", 32'(data), 32'h12);

      // Latency from start edge to valid
      send_frame(8'h5A, 16, 1'b1);
      repeat (40) @(negedge clk);
      check("lat_count", n_valid, 10);
      check("lat_data", 32'(data), 32'h5A);
      lat = valid_cyc - start_cyc;
      n_cmp = n_cmp + 1;
      assert (lat >= 153 && lat <= 155) else begin
         n_fail = n_fail + 1;
         $error("FAIL latency: observed %0d expected 154 +/-1", lat);
      end

      check("never_both", n_both, 0);
      check("total_ferr", n_ferr, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
